adf4159_spi_capture: RTL and testbench

//  Receive end of the ADF4159 3-wire write bus (SClk/Data/LE): capture 32-bit words, decode control bits, keep an 11-entry shadow register bank.

---
 rtl/adf4159_spi_capture_if.sv | 18 +
 rtl/adf4159_spi_capture.sv | 205 ++++++++++++++++++++
 tb/tb_adf4159_spi_capture.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adf4159_spi_capture_if.sv
// ----------------------------------------------------------------------------
// adf4159_spi_capture_if
// Three-wire ADF4159 write bus (serial clock, serial data, load enable).
//   SClk   serial clock, data valid on its rising edge
//   Data   serial data, MSB first
//   Latch  load enable; low while a frame is active, rising edge latches
// Modports:
//   master  the synth driver side (drives all three wires)
//   slave   the capture side (samples all three wires)
// ----------------------------------------------------------------------------
interface adf4159_spi_capture_if;
    logic SClk;
    logic Data;
    logic Latch;

    modport master (output SClk, output Data, output Latch);
    modport slave  (input  SClk, input  Data, input  Latch);
endinterface

// File: rtl/adf4159_spi_capture.sv
// ----------------------------------------------------------------------------
// adf4159_spi_capture
// Receive end of the ADF4159 write bus. Captures 32-bit words, decodes the
// register address bits into one of 11 shadow slots and keeps the active
// INT/FRAC/ramp-enable settings, which only change on an R0 write (R1 is
// double buffered behind R0, as in the PLL itself).
// Ports:
//   ipClk         system clock (>= 8x serial clock rate)
//   ipReset       asynchronous active-low reset
//   spiBus        three-wire write bus (slave side)
//   ipReadSel     shadow slot select 0..10, combinational read
//   opRegister    shadow word at ipReadSel, 0 for selects 11..15
//   opWord        last accepted word
//   opSlot        slot of last accepted word
//   opValid       one-cycle pulse: word accepted
//   opFrameError  one-cycle pulse: frame ended with bit count other than 32
//   opInteger     active INT value (R0[26:15])
//   opFraction    active FRAC value {R0[14:3], R1[27:15]}
//   opRampOn      active ramp enable (R0[31])
//   opFreqUpdate  one-cycle pulse: opInteger/opFraction/opRampOn reloaded
// ----------------------------------------------------------------------------
module adf4159_spi_capture #(
    parameter int Sync_Stages = 2
) (
    input  logic                        ipClk,
    input  logic                        ipReset,
    adf4159_spi_capture_if.slave        spiBus,
    input  logic [3:0]                  ipReadSel,
    output logic [31:0]                 opRegister,
    output logic [31:0]                 opWord,
    output logic [3:0]                  opSlot,
    output logic                        opValid,
    output logic                        opFrameError,
    output logic [11:0]                 opInteger,
    output logic [24:0]                 opFraction,
    output logic                        opRampOn,
    output logic                        opFreqUpdate
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    // Map the control bits of a word onto its shadow slot. R4/R5/R6 each
    // have two physical registers selected by a sub-address bit.
    function automatic logic [3:0] slotOf(input logic [31:0] w);
        logic [3:0] s;
        case (w[2:0])
            3'd0:    s = 4'd0;
            3'd1:    s = 4'd1;
            3'd2:    s = 4'd2;
            3'd3:    s = 4'd3;
            3'd4:    s = w[6]  ? 4'd5 : 4'd4;
            3'd5:    s = w[23] ? 4'd7 : 4'd6;
            3'd6:    s = w[23] ? 4'd9 : 4'd8;
            3'd7:    s = 4'd10;
            default: s = 4'd0;
        endcase
        return s;
    endfunction

    logic [Sync_Stages-1:0] sclkSync_r;
    logic [Sync_Stages-1:0] dataSync_r;
    logic [Sync_Stages-1:0] latchSync_r;
    logic                   sclkPrev_r;
    logic                   latchPrev_r;

    logic                   sclkRise_s;
    logic                   latchRise_s;
    logic                   latchFall_s;
    logic                   dataBit_s;
    logic [3:0]             commitSlot_s;

    logic [1:0]             state_r;
    logic [31:0]            shift_r;
    logic [5:0]             count_r;
    logic [31:0]            shadow_r [0:10];

    logic [31:0]            word_r;
    logic [3:0]             slot_r;
    logic                   valid_r;
    logic                   frameError_r;
    logic [11:0]            integer_r;
    logic [24:0]            fraction_r;
    logic                   rampOn_r;
    logic                   freqUpdate_r;

    // Synchronise the bus wires and keep one extra flop for edge detection.
    // Reset values of 0 mean a low LE at reset release is not seen as a
    // falling edge, so a frame interrupted by reset is never half-captured.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            sclkSync_r  <= {Sync_Stages{1'b0}};
            dataSync_r  <= {Sync_Stages{1'b0}};
            latchSync_r <= {Sync_Stages{1'b0}};
            sclkPrev_r  <= 1'b0;
            latchPrev_r <= 1'b0;
        end else begin
            sclkSync_r  <= {sclkSync_r[Sync_Stages-2:0],  spiBus.SClk};
            dataSync_r  <= {dataSync_r[Sync_Stages-2:0],  spiBus.Data};
            latchSync_r <= {latchSync_r[Sync_Stages-2:0], spiBus.Latch};
            sclkPrev_r  <= sclkSync_r[Sync_Stages-1];
            latchPrev_r <= latchSync_r[Sync_Stages-1];
        end
    end

    assign sclkRise_s   = sclkSync_r[Sync_Stages-1]  & ~sclkPrev_r;
    assign latchRise_s  = latchSync_r[Sync_Stages-1] & ~latchPrev_r;
    assign latchFall_s  = ~latchSync_r[Sync_Stages-1] & latchPrev_r;
    assign dataBit_s    = dataSync_r[Sync_Stages-1];
    assign commitSlot_s = slotOf(shift_r);

    // Frame state machine, shift register, shadow bank and output registers.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_r      <= ST_IDLE;
            shift_r      <= 32'd0;
            count_r      <= 6'd0;
            for (int i = 0; i < 11; i++) begin
                shadow_r[i] <= 32'd0;
            end
            word_r       <= 32'd0;
            slot_r       <= 4'd0;
            valid_r      <= 1'b0;
            frameError_r <= 1'b0;
            integer_r    <= 12'd0;
            fraction_r   <= 25'd0;
            rampOn_r     <= 1'b0;
            freqUpdate_r <= 1'b0;
        end else begin
            valid_r      <= 1'b0;
            frameError_r <= 1'b0;
            freqUpdate_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    count_r <= 6'd0;
                    if (latchFall_s) begin
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // LE rising takes priority over a coincident SClk edge.
                    if (latchRise_s) begin
                        state_r <= ST_LATCH;
                    end else if (sclkRise_s) begin
                        shift_r <= {shift_r[30:0], dataBit_s};
                        if (count_r != 6'd33) begin
                            count_r <= count_r + 6'd1;
                        end else begin
                            count_r <= count_r;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_LATCH: begin
                    state_r <= ST_IDLE;
                    if (count_r == 6'd32) begin
                        shadow_r[commitSlot_s] <= shift_r;
                        word_r  <= shift_r;
                        slot_r  <= commitSlot_s;
                        valid_r <= 1'b1;
                        // R0 commit loads the active frequency using
                        // whatever R1 currently sits in the shadow bank.
                        if (commitSlot_s == 4'd0) begin
                            integer_r    <= shift_r[26:15];
                            fraction_r   <= {shift_r[14:3], shadow_r[1][27:15]};
                            rampOn_r     <= shift_r[31];
                            freqUpdate_r <= 1'b1;
                        end else begin
                            freqUpdate_r <= 1'b0;
                        end
                    end else begin
                        frameError_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Combinational shadow readback; unused selects read as zero.
    always_comb begin
        opRegister = 32'd0;
        if (ipReadSel <= 4'd10) begin
            opRegister = shadow_r[ipReadSel];
        end else begin
            opRegister = 32'd0;
        end
    end

    assign opWord       = word_r;
    assign opSlot       = slot_r;
    assign opValid      = valid_r;
    assign opFrameError = frameError_r;
    assign opInteger    = integer_r;
    assign opFraction   = fraction_r;
    assign opRampOn     = rampOn_r;
    assign opFreqUpdate = freqUpdate_r;

endmodule

// File: tb/tb_adf4159_spi_capture.sv
// ----------------------------------------------------------------------------
// tb_adf4159_spi_capture
// Directed bench for adf4159_spi_capture: drives the three-wire bus through
// an interface instance and checks captured words, slot decode, double
// buffered frequency outputs, frame errors and reset behaviour.
// ----------------------------------------------------------------------------
module tb_adf4159_spi_capture;

    localparam int FastHalf = 100;   // serial half period, ~10 clk per bit
    localparam int SlowHalf = 500;   // 1 MHz serial vs 50 MHz system clock

    logic        clk;
    logic        ipReset;
    logic [3:0]  ipReadSel;
    logic [31:0] opRegister;
    logic [31:0] opWord;
    logic [3:0]  opSlot;
    logic        opValid;
    logic        opFrameError;
    logic [11:0] opInteger;
    logic [24:0] opFraction;
    logic        opRampOn;
    logic        opFreqUpdate;

    int checks = 0;
    int passes = 0;
    int validCount = 0;
    int errCount = 0;
    int freqCount = 0;

    adf4159_spi_capture_if spiBus ();

    adf4159_spi_capture #(.Sync_Stages(2)) dut (
        .ipClk        (clk),
        .ipReset      (ipReset),
        .spiBus       (spiBus.slave),
        .ipReadSel    (ipReadSel),
        .opRegister   (opRegister),
        .opWord       (opWord),
        .opSlot       (opSlot),
        .opValid      (opValid),
        .opFrameError (opFrameError),
        .opInteger    (opInteger),
        .opFraction   (opFraction),
        .opRampOn     (opRampOn),
        .opFreqUpdate (opFreqUpdate)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (opValid)      validCount <= validCount + 1;
        if (opFrameError) errCount   <= errCount + 1;
        if (opFreqUpdate) freqCount  <= freqCount + 1;
    end

    task automatic waitClks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sendFrame(input logic [31:0] w, input int nbits, input int half);
        spiBus.Latch = 1'b0;
        #(half);
        for (int i = 0; i < nbits; i++) begin
            spiBus.Data = (i < 32) ? w[31 - i] : 1'b0;
            #(half);
            spiBus.SClk = 1'b1;
            #(half);
            spiBus.SClk = 1'b0;
        end
        #(half);
        spiBus.Latch = 1'b1;
        waitClks(12);
    endtask

    task automatic readSlot(input logic [3:0] sel, input logic [31:0] exp, input string name);
        ipReadSel = sel;
        #1;
        checks++;
        if (opRegister !== exp) $display("FAIL %s: slot %0d got %h expected %h", name, sel, opRegister, exp);
        else passes++;
    endtask

    task automatic test_reset;
        spiBus.SClk  = 1'b0;
        spiBus.Data  = 1'b0;
        spiBus.Latch = 1'b1;
        ipReadSel    = 4'd0;
        ipReset      = 1'b0;
        waitClks(5);
        ipReset = 1'b1;
        waitClks(10);   // LE high at release: rising edge in Idle, ignored
        checks++; if (opWord !== 32'd0) $display("FAIL reset_word: got %h expected 0", opWord); else passes++;
        checks++; if (opSlot !== 4'd0) $display("FAIL reset_slot: got %0d expected 0", opSlot); else passes++;
        checks++; if ({opInteger, opFraction, opRampOn} !== 38'd0)
            $display("FAIL reset_freq: got %h/%h/%b expected 0", opInteger, opFraction, opRampOn); else passes++;
        checks++; if (validCount + errCount + freqCount !== 0)
            $display("FAIL reset_pulses: got %0d expected 0", validCount + errCount + freqCount); else passes++;
        readSlot(4'd0, 32'd0, "reset_shadow");
    endtask

    task automatic test_r0;
        int v0 = validCount;
        int f0 = freqCount;
        sendFrame(32'h8012_8008, 32, FastHalf);
        checks++; if (validCount !== v0 + 1) $display("FAIL r0_valid: got %0d expected %0d", validCount, v0 + 1); else passes++;
        checks++; if (freqCount !== f0 + 1) $display("FAIL r0_frequpd: got %0d expected %0d", freqCount, f0 + 1); else passes++;
        checks++; if (opSlot !== 4'd0) $display("FAIL r0_slot: got %0d expected 0", opSlot); else passes++;
        checks++; if (opWord !== 32'h8012_8008) $display("FAIL r0_word: got %h expected 80128008", opWord); else passes++;
        checks++; if (opInteger !== 12'h025) $display("FAIL r0_int: got %h expected 025", opInteger); else passes++;
        checks++; if (opFraction !== 25'h0002000) $display("FAIL r0_frac: got %h expected 0002000", opFraction); else passes++;
        checks++; if (opRampOn !== 1'b1) $display("FAIL r0_ramp: got %b expected 1", opRampOn); else passes++;
        readSlot(4'd0, 32'h8012_8008, "r0_shadow");
    endtask

    task automatic test_double_buffer;
        int v0 = validCount;
        int f0 = freqCount;
        sendFrame(32'h0000_8001, 32, FastHalf);
        checks++; if (validCount !== v0 + 1) $display("FAIL r1_valid: got %0d expected %0d", validCount, v0 + 1); else passes++;
        checks++; if (freqCount !== f0) $display("FAIL r1_no_frequpd: got %0d expected %0d", freqCount, f0); else passes++;
        checks++; if (opSlot !== 4'd1) $display("FAIL r1_slot: got %0d expected 1", opSlot); else passes++;
        checks++; if (opFraction !== 25'h0002000) $display("FAIL r1_frac_held: got %h expected 0002000", opFraction); else passes++;
        readSlot(4'd1, 32'h0000_8001, "r1_shadow");
        sendFrame(32'h8012_8008, 32, FastHalf);
        checks++; if (freqCount !== f0 + 1) $display("FAIL r0b_frequpd: got %0d expected %0d", freqCount, f0 + 1); else passes++;
        checks++; if (opFraction !== 25'h0002001) $display("FAIL r0b_frac: got %h expected 0002001", opFraction); else passes++;
    endtask

    task automatic test_slots;
        logic [31:0] words [6] = '{32'h0000_0044, 32'h0018_0004, 32'h0080_0005,
                                   32'h0000_0015, 32'h0080_0006, 32'h0000_0026};
        logic [3:0]  slots [6] = '{4'd5, 4'd4, 4'd7, 4'd6, 4'd9, 4'd8};
        for (int i = 0; i < 6; i++) begin
            sendFrame(words[i], 32, FastHalf);
            checks++;
            if (opSlot !== slots[i]) $display("FAIL slot_decode: word %h got %0d expected %0d", words[i], opSlot, slots[i]);
            else passes++;
        end
        for (int i = 0; i < 6; i++) readSlot(slots[i], words[i], "slot_hold");
        readSlot(4'd2,  32'd0, "slot_untouched");
        readSlot(4'd3,  32'd0, "slot_untouched");
        readSlot(4'd10, 32'd0, "slot_untouched");
        for (int s = 11; s < 16; s++) readSlot(4'(s), 32'd0, "sel_out_of_range");
    endtask

    task automatic test_frame_errors;
        int v0 = validCount;
        int e0 = errCount;
        sendFrame(32'hFFFF_FFF8, 31, FastHalf);
        checks++; if (errCount !== e0 + 1) $display("FAIL short_err: got %0d expected %0d", errCount, e0 + 1); else passes++;
        checks++; if (validCount !== v0) $display("FAIL short_novalid: got %0d expected %0d", validCount, v0); else passes++;
        sendFrame(32'hFFFF_FFF8, 40, FastHalf);
        checks++; if (errCount !== e0 + 2) $display("FAIL long_err: got %0d expected %0d", errCount, e0 + 2); else passes++;
        checks++; if (validCount !== v0) $display("FAIL long_novalid: got %0d expected %0d", validCount, v0); else passes++;
        readSlot(4'd0, 32'h8012_8008, "err_shadow_r0");
        readSlot(4'd10, 32'd0, "err_shadow_r7");
    endtask

    task automatic test_le_wins;
        logic [31:0] w = 32'h0000_0003;
        int v0 = validCount;
        int e0 = errCount;
        spiBus.Latch = 1'b0;
        #(FastHalf);
        for (int i = 0; i < 32; i++) begin
            spiBus.Data = w[31 - i];
            #(FastHalf);
            spiBus.SClk = 1'b1;
            #(FastHalf);
            spiBus.SClk = 1'b0;
        end
        spiBus.Data = 1'b1;
        #(FastHalf);
        spiBus.SClk  = 1'b1;
        spiBus.Latch = 1'b1;
        #(FastHalf);
        spiBus.SClk = 1'b0;
        waitClks(12);
        checks++; if (validCount !== v0 + 1) $display("FAIL lewins_valid: got %0d expected %0d", validCount, v0 + 1); else passes++;
        checks++; if (errCount !== e0) $display("FAIL lewins_noerr: got %0d expected %0d", errCount, e0); else passes++;
        checks++; if (opWord !== 32'h0000_0003) $display("FAIL lewins_word: got %h expected 00000003", opWord); else passes++;
    endtask

    task automatic test_driver_sequence;
        logic [31:0] words [11] = '{32'h0000_0007, 32'h00A0_0006, 32'h0030_0006, 32'h0180_0005,
                                    32'h0040_0005, 32'h00C0_0044, 32'h00C0_0004, 32'h0043_0083,
                                    32'h0700_800A, 32'h0001_0001, 32'h0004_C010};
        logic [31:0] expSlot [11] = '{32'h0004_C010, 32'h0001_0001, 32'h0700_800A, 32'h0043_0083,
                                      32'h00C0_0004, 32'h00C0_0044, 32'h0040_0005, 32'h0180_0005,
                                      32'h0030_0006, 32'h00A0_0006, 32'h0000_0007};
        int v0 = validCount;
        for (int i = 0; i < 11; i++) sendFrame(words[i], 32, SlowHalf);
        checks++; if (validCount !== v0 + 11) $display("FAIL seq_valid: got %0d expected %0d", validCount, v0 + 11); else passes++;
        for (int s = 0; s < 11; s++) readSlot(4'(s), expSlot[s], "seq_sweep");
        checks++; if (opInteger !== 12'h009) $display("FAIL seq_int: got %h expected 009", opInteger); else passes++;
        checks++; if (opFraction !== 25'h1004002) $display("FAIL seq_frac: got %h expected 1004002", opFraction); else passes++;
        checks++; if (opRampOn !== 1'b0) $display("FAIL seq_ramp: got %b expected 0", opRampOn); else passes++;
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] w = 32'hF0F0_F0F0;
        int e0;
        int v0;
        ipReadSel = 4'd0;
        spiBus.Latch = 1'b0;
        #(FastHalf);
        for (int i = 0; i < 16; i++) begin
            spiBus.Data = w[31 - i];
            #(FastHalf);
            spiBus.SClk = 1'b1;
            #(FastHalf);
            spiBus.SClk = 1'b0;
        end
        ipReset = 1'b0;
        #1;
        checks++; if ({opWord, opSlot} !== 36'd0) $display("FAIL midrst_word: got %h/%0d expected 0", opWord, opSlot); else passes++;
        checks++; if ({opInteger, opFraction, opRampOn} !== 38'd0)
            $display("FAIL midrst_freq: got %h/%h/%b expected 0", opInteger, opFraction, opRampOn); else passes++;
        checks++; if (opRegister !== 32'd0) $display("FAIL midrst_shadow: got %h expected 0", opRegister); else passes++;
        waitClks(3);
        ipReset = 1'b1;
        waitClks(5);
        e0 = errCount;
        v0 = validCount;
        spiBus.Latch = 1'b1;   // end of the interrupted frame, seen in Idle
        waitClks(10);
        checks++; if (errCount !== e0 || validCount !== v0)
            $display("FAIL midrst_ignored: got err %0d valid %0d expected %0d %0d", errCount, validCount, e0, v0); else passes++;
        sendFrame(32'h1234_0002, 32, FastHalf);
        checks++; if (validCount !== v0 + 1) $display("FAIL midrst_next_valid: got %0d expected %0d", validCount, v0 + 1); else passes++;
        readSlot(4'd2, 32'h1234_0002, "midrst_next_word");
        readSlot(4'd0, 32'd0, "midrst_r0_cleared");
    endtask

    initial begin
        test_reset();
        test_r0();
        test_double_buffer();
        test_slots();
        test_frame_errors();
        test_le_wins();
        test_driver_sequence();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
